mm_result_collector: RTL and testbench
======================================

# mm_result_collector

Downstream stage of the matrix-multiply engine. Captures each 40-bit signed result the engine emits on its write strobe, stores it row-major in an internal result buffer, tracks the current row/column position, accumulates a wrapping checksum, and flags count mismatches against the announced result dimensions. A registered read port lets the host or a later stage read results back after completion.

## Interface
Parameters:
- DW, 40, result word width (signed)
- AW, 6, buffer address width; depth = 2^AW entries
- CW, 48, checksum width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches rows/cols and arms collection
- rows  in  20  result row count (engine row1)
- cols  in  20  result column count (engine col2)
- wr_valid  in  1  engine write strobe; one result per high cycle
- wr_data  in  DW  signed result word
- mm_finish  in  1  engine finish flag (level)
- rd_addr  in  AW  readback address
- rd_data  out  DW  registered readback data
- row_idx  out  20  row of next result to be stored
- col_idx  out  20  column of next result to be stored
- count  out  AW+1  results stored since last start
- checksum  out  CW  wrapping sum of sign-extended stored results
- done  out  1  all rows*cols results stored
- err  out  1  sticky error
- err_code  out  2  0 none, 1 bad dims, 2 early finish, 3 excess write

## Operation
- Reset (reset=0, async): state IDLE; rd_data, row_idx, col_idx, count, checksum = 0; done=0, err=0, err_code=0; buffer contents undefined.
- States: IDLE, COLLECT, DONE, ERROR.
- start in any state: latch rows/cols, clear row_idx, col_idx, count, checksum, done, err, err_code. Next state: ERROR with code 1 if rows==0, cols==0, or rows*cols > 2^AW; else COLLECT. start takes priority over all same-cycle events; a wr_valid coinciding with start is discarded.
- IDLE: wr_valid and mm_finish ignored (engine drives its write strobe during header fetch; that must never be captured).
- COLLECT, wr_valid=1: buffer[count] <= wr_data; count+1; checksum += sign-extend(wr_data) mod 2^CW; col_idx+1, wrapping to 0 with row_idx+1 when col_idx == cols-1. When the stored word makes count == rows*cols: go DONE, row_idx/col_idx hold final-wrapped values (row_idx = rows, col_idx = 0).
- COLLECT, mm_finish=1 with count (after any same-cycle write) < rows*cols: go ERROR, code 2. Finish on the same cycle as the final write is legal -> DONE.
- DONE: done=1 held. wr_valid -> ERROR, code 3, done cleared; word not stored, count/checksum unchanged. mm_finish ignored.
- ERROR: err=1, err_code held; writes ignored; exits only on start or reset.
- Readback: any state. rd_data <= buffer[rd_addr] if rd_addr < count, else 0.
- Arithmetic: rows*cols computed at 40 bits for the range check; checksum sign-extends DW to CW and wraps silently.

## Timing
- wr_data sampled on the rising edge with wr_valid=1; count, indices, checksum visible the next cycle.
- done rises the cycle after the final accepted write; err rises the cycle after the offending event (or after start for code 1).
- rd_data latency 1 cycle. Same-cycle write and read of the same address returns old content; since rd_addr < count is evaluated against pre-write count, a not-yet-stored address returns 0.
- Back-to-back wr_valid on consecutive cycles sustained at one word per cycle.
- reset mid-COLLECT: all outputs return to reset values immediately; a subsequent start is required.

## Test plan
- start rows=2 cols=2; writes 5, -3, 7, 10 on separate cycles -> count=4, done=1 one cycle after last write, checksum=19, reads addr 0..3 return 5, -3, 7, 10; addr 4 returns 0.
- start rows=1 cols=3; writes -1, -1, -2^39 -> checksum = 0xFF7F_FFFF_FFFE (48-bit wrap of -2^39-2), done=1, row_idx=1 col_idx=0.
- start rows=0 cols=4, and separately rows=9 cols=8 (AW=6) -> err=1 err_code=1 next cycle; later wr_valid pulses leave count=0.
- start rows=2 cols=2; two writes then mm_finish=1 -> err_code=2, done=0, count=2; mm_finish together with fourth write in a fresh run -> done=1, err=0.
- rows=1 cols=1, one write reaching DONE, then another wr_valid -> err_code=3, done=0, count=1, checksum unchanged; wr_valid asserted while in IDLE before start -> count stays 0.
- Reset pulled low after 3 of 4 writes -> all outputs 0 asynchronously; start again, 4 writes -> done=1, count=4, correct readback.

Source files
------------

// File: rtl/mm_result_collector.sv
// mm_result_collector: captures signed results from the matrix-multiply
// engine into a row-major buffer. It tracks the row/column of the next
// result, keeps a wrapping checksum and flags count or ordering errors
// against the dimensions announced at start. A registered read port returns
// stored words; addresses that have not been written yet read as zero.
//
// Handshake: wr_valid is a one-cycle strobe with no back-pressure. Each
// cycle with wr_valid high offers one word on wr_data. The word is taken
// only in COLLECT, and only when start is low in the same cycle.
module mm_result_collector #(
    parameter int DW = 40,
    parameter int AW = 6,
    parameter int CW = 48
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [19:0]   rows,
    input  logic [19:0]   cols,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          mm_finish,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [19:0]   row_idx,
    output logic [19:0]   col_idx,
    output logic [AW:0]   count,
    output logic [CW-1:0] checksum,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    localparam int          PW    = 40;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** AW);

    state_e          state_q,    state_d;
    logic [19:0]     cols_q,     cols_d;
    logic [PW-1:0]   total_q,    total_d;
    logic [19:0]     row_idx_q,  row_idx_d;
    logic [19:0]     col_idx_q,  col_idx_d;
    logic [AW:0]     count_q,    count_d;
    logic [CW-1:0]   checksum_q, checksum_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [DW-1:0]   rd_data_q,  rd_data_d;
    logic            wr_en;

    logic [DW-1:0]   mem [2**AW];

    logic [PW-1:0]   start_prod;
    logic            start_bad;
    logic [AW:0]     count_inc;
    logic            last_col;
    logic            wr_last;
    logic [CW-1:0]   wr_sext;

    // Derived values for start checking and for the write path.
    always_comb begin
        start_prod = PW'(rows) * PW'(cols);
        start_bad  = (rows == 20'd0) || (cols == 20'd0) || (start_prod > DEPTH);
        count_inc  = count_q + 1'b1;
        last_col   = (col_idx_q == (cols_q - 20'd1));
        wr_last    = (PW'(count_inc) == total_q);
        wr_sext    = {{(CW-DW){wr_data[DW-1]}}, wr_data};
    end

    // Next-state logic. start overrides every other event in the same cycle.
    always_comb begin
        state_d    = state_q;
        cols_d     = cols_q;
        total_d    = total_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        err_code_d = err_code_q;
        wr_en      = 1'b0;
        if (start) begin
            cols_d     = cols;
            total_d    = start_prod;
            row_idx_d  = '0;
            col_idx_d  = '0;
            count_d    = '0;
            checksum_d = '0;
            if (start_bad) begin
                state_d    = ST_ERROR;
                err_code_d = 2'd1;
            end else begin
                state_d    = ST_COLLECT;
                err_code_d = 2'd0;
            end
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (wr_valid) begin
                        wr_en      = 1'b1;
                        count_d    = count_inc;
                        checksum_d = checksum_q + wr_sext;
                        if (last_col) begin
                            col_idx_d = '0;
                            row_idx_d = row_idx_q + 20'd1;
                        end else begin
                            col_idx_d = col_idx_q + 20'd1;
                        end
                    end
                    // A finish together with the final write is a clean finish.
                    if (wr_valid && wr_last) begin
                        state_d = ST_DONE;
                    end else if (mm_finish) begin
                        state_d    = ST_ERROR;
                        err_code_d = 2'd2;
                    end
                end
                ST_DONE: begin
                    if (wr_valid) begin
                        state_d    = ST_ERROR;
                        err_code_d = 2'd3;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Readback selects the stored word. It uses the count from before any
    // write in the same cycle, so an address that is still empty reads as 0.
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < count_q) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cols_q     <= '0;
            total_q    <= '0;
            row_idx_q  <= '0;
            col_idx_q  <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            err_code_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            total_q    <= total_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            err_code_q <= err_code_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Result buffer. It has no reset because its contents are undefined
    // until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign row_idx     = row_idx_q;
    assign col_idx     = col_idx_q;
    assign count       = count_q;
    assign checksum    = checksum_q;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERROR);
    assign err_code    = err_code_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector. Stored words go into a queue of
// expected values and are popped as they are read back.
module tb_mm_result_collector;

    localparam int DW = 40;
    localparam int AW = 6;
    localparam int CW = 48;

    logic          clk;
    logic          reset;
    logic          start;
    logic [19:0]   rows;
    logic [19:0]   cols;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          mm_finish;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [19:0]   row_idx;
    logic [19:0]   col_idx;
    logic [AW:0]   count;
    logic [CW-1:0] checksum;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [1:0]    dbg_state_o;

    int            total;
    int            bad;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_sum;

    mm_result_collector #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .rows(rows), .cols(cols),
        .wr_valid(wr_valid), .wr_data(wr_data), .mm_finish(mm_finish),
        .rd_addr(rd_addr), .rd_data(rd_data), .row_idx(row_idx),
        .col_idx(col_idx), .count(count), .checksum(checksum), .done(done),
        .err(err), .err_code(err_code), .dbg_state_o(dbg_state_o)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks. Each one starts just after a falling edge and returns
    // on the next falling edge, so the outputs can be sampled away from the
    // rising edge.
    task automatic do_start(input logic [19:0] r, input logic [19:0] c, input bit with_wr);
        start    = 1'b1;
        rows     = r;
        cols     = c;
        wr_valid = with_wr;
        wr_data  = 40'd99;
        exp_q.delete();
        exp_sum  = '0;
        @(negedge clk);
        start    = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic do_write(input logic signed [DW-1:0] d, input bit store, input bit fin);
        wr_valid  = 1'b1;
        wr_data   = d;
        mm_finish = fin;
        if (store) begin
            exp_q.push_back(d);
            exp_sum = exp_sum + {{(CW-DW){d[DW-1]}}, d};
        end
        @(negedge clk);
        wr_valid  = 1'b0;
        mm_finish = 1'b0;
    endtask

    task automatic do_finish();
        mm_finish = 1'b1;
        @(negedge clk);
        mm_finish = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic read_pop(input logic [AW-1:0] a, input string tag);
        logic [DW-1:0] e;
        rd_addr = a;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, rd_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(rd_data), 64'(e));
        end
    endtask

    task automatic read_zero(input logic [AW-1:0] a, input string tag);
        rd_addr = a;
        @(negedge clk);
        check(tag, 64'(rd_data), 64'd0);
    endtask

    initial begin
        logic signed [DW-1:0] min_val;
        total = 0;
        bad = 0;
        exp_sum = '0;
        reset = 1'b0;
        start = 1'b0;
        rows = '0;
        cols = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        mm_finish = 1'b0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_sum", 64'(checksum), 64'd0);
        check("rst_flags", {61'd0, done, err, 1'b0}, 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'd0);
        reset = 1'b1;
        idle();

        // Writes and finish pulses in IDLE are ignored.
        do_write(40'd11, 1'b0, 1'b0);
        do_write(40'd12, 1'b0, 1'b0);
        do_finish();
        check("idle_count", 64'(count), 64'd0);
        check("idle_state", 64'(dbg_state_o), 64'd0);
        check("idle_err", 64'(err), 64'd0);

        // 2x2 with gaps between the writes.
        do_start(20'd2, 20'd2, 1'b0);
        check("t1_state", 64'(dbg_state_o), 64'd1);
        do_write(40'sd5, 1'b1, 1'b0);
        check("t1_cnt1", 64'(count), 64'd1);
        check("t1_col1", 64'(col_idx), 64'd1);
        check("t1_row1", 64'(row_idx), 64'd0);
        idle();
        do_write(-40'sd3, 1'b1, 1'b0);
        check("t1_col_wrap", 64'(col_idx), 64'd0);
        check("t1_row_inc", 64'(row_idx), 64'd1);
        idle();
        do_write(40'sd7, 1'b1, 1'b0);
        check("t1_done_early", 64'(done), 64'd0);
        idle();
        do_write(40'sd10, 1'b1, 1'b0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_count", 64'(count), 64'd4);
        check("t1_sum19", 64'(checksum), 64'd19);
        check("t1_sum", 64'(checksum), 64'(exp_sum));
        check("t1_row", 64'(row_idx), 64'd2);
        check("t1_col", 64'(col_idx), 64'd0);
        for (int i = 0; i < 4; i++) read_pop(AW'(i), "t1_rd");
        read_zero(6'd4, "t1_rd4");
        read_zero(6'd5, "t1_rd5");

        // 1x3 with a write during the start cycle, then a negative wrap.
        do_start(20'd1, 20'd3, 1'b1);
        check("t2_start_wr_count", 64'(count), 64'd0);
        check("t2_start_wr_sum", 64'(checksum), 64'd0);
        min_val = {1'b1, 39'd0};
        do_write(-40'sd1, 1'b1, 1'b0);
        do_write(-40'sd1, 1'b1, 1'b0);
        do_write(min_val, 1'b1, 1'b0);
        check("t2_sum_const", 64'(checksum), 64'hFF7F_FFFF_FFFE);
        check("t2_sum", 64'(checksum), 64'(exp_sum));
        check("t2_done", 64'(done), 64'd1);
        check("t2_row", 64'(row_idx), 64'd1);
        check("t2_col", 64'(col_idx), 64'd0);
        for (int i = 0; i < 3; i++) read_pop(AW'(i), "t2_rd");

        // Dimension checks.
        do_start(20'd0, 20'd4, 1'b0);
        check("t3_zero_err", 64'(err), 64'd1);
        check("t3_zero_code", 64'(err_code), 64'd1);
        do_write(40'd1, 1'b0, 1'b0);
        do_write(40'd2, 1'b0, 1'b0);
        check("t3_zero_count", 64'(count), 64'd0);
        do_start(20'd9, 20'd8, 1'b0);
        check("t3_big_code", 64'(err_code), 64'd1);
        do_write(40'd3, 1'b0, 1'b0);
        check("t3_big_count", 64'(count), 64'd0);
        do_start(20'd8, 20'd8, 1'b0);
        check("t3_full_err", 64'(err), 64'd0);
        check("t3_full_state", 64'(dbg_state_o), 64'd1);
        for (int i = 0; i < 64; i++) begin
            do_write(DW'({$urandom, $urandom}), 1'b1, 1'b0);
        end
        check("t3_full_done", 64'(done), 64'd1);
        check("t3_full_count", 64'(count), 64'd64);
        check("t3_full_sum", 64'(checksum), 64'(exp_sum));
        check("t3_full_row", 64'(row_idx), 64'd8);
        for (int i = 0; i < 64; i++) read_pop(AW'(i), "t3_rd");

        // Early finish, then a finish that arrives with the final write.
        do_start(20'd2, 20'd2, 1'b0);
        do_write(40'd1, 1'b1, 1'b0);
        do_write(40'd2, 1'b1, 1'b0);
        do_finish();
        check("t4_code", 64'(err_code), 64'd2);
        check("t4_err", 64'(err), 64'd1);
        check("t4_done", 64'(done), 64'd0);
        check("t4_count", 64'(count), 64'd2);
        do_start(20'd2, 20'd2, 1'b0);
        do_write(40'd4, 1'b1, 1'b0);
        do_write(40'd5, 1'b1, 1'b0);
        do_write(40'd6, 1'b1, 1'b0);
        do_write(40'd7, 1'b1, 1'b1);
        check("t4_fin_done", 64'(done), 64'd1);
        check("t4_fin_err", 64'(err), 64'd0);
        do_finish();
        check("t4_fin_ign", 64'(done), 64'd1);

        // An extra write after DONE.
        do_start(20'd1, 20'd1, 1'b0);
        do_write(40'd42, 1'b1, 1'b0);
        check("t5_done", 64'(done), 64'd1);
        do_write(40'd77, 1'b0, 1'b0);
        check("t5_code", 64'(err_code), 64'd3);
        check("t5_done_clr", 64'(done), 64'd0);
        check("t5_count", 64'(count), 64'd1);
        check("t5_sum", 64'(checksum), 64'd42);
        read_pop(6'd0, "t5_rd");
        read_zero(6'd1, "t5_rd1");

        // Asynchronous reset in the middle of collection.
        do_start(20'd2, 20'd2, 1'b0);
        do_write(40'd8, 1'b1, 1'b0);
        do_write(40'd9, 1'b1, 1'b0);
        do_write(40'd10, 1'b1, 1'b0);
        rd_addr = 6'd0;
        #2 reset = 1'b0;
        #1;
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_sum", 64'(checksum), 64'd0);
        check("t6_rst_idx", {24'd0, row_idx, col_idx}, 64'd0);
        check("t6_rst_state", 64'(dbg_state_o), 64'd0);
        check("t6_rst_rd", 64'(rd_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        idle();
        check("t6_idle", 64'(dbg_state_o), 64'd0);
        do_start(20'd2, 20'd2, 1'b0);
        do_write(40'd21, 1'b1, 1'b0);
        do_write(-40'sd22, 1'b1, 1'b0);
        do_write(40'd23, 1'b1, 1'b0);
        do_write(40'd24, 1'b1, 1'b0);
        check("t6_done", 64'(done), 64'd1);
        check("t6_count", 64'(count), 64'd4);
        check("t6_sum", 64'(checksum), 64'(exp_sum));
        for (int i = 0; i < 4; i++) read_pop(AW'(i), "t6_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above never finishes.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
